// File: rtl/serial_compare_16_pkg.sv
// ---------------------------------------------------------------------------
// serial_cmp_pkg
// Shared definitions for the nibble-serial magnitude comparator:
//   stateT             - controller states (IDLE / RUN / DONE)
//   GT_BIT/LT_BIT/EQ_BIT - bit positions inside the 3-bit one-hot result
//   FLAGS_EQ           - cascade flag value meaning "equal so far"
// ---------------------------------------------------------------------------
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int GT_BIT = 2;
    localparam int LT_BIT = 1;
    localparam int EQ_BIT = 0;

    localparam logic [2:0] FLAGS_EQ = 3'b001;

endpackage

// File: rtl/serial_compare_16_if.sv
// ---------------------------------------------------------------------------
// serial_compare_16_if
// Request/result bundle of the serial comparator.
//   iStart   - start request (driven by master)
//   iData_a  - operand A, WIDTH bits (driven by master)
//   iData_b  - operand B, WIDTH bits (driven by master)
//   oBusy    - compare in progress (driven by slave)
//   oDone    - one-cycle completion pulse (driven by slave)
//   oData    - one-hot result {gt, lt, eq} (driven by slave)
// WIDTH must match the WIDTH of the comparator instance it connects to.
// ---------------------------------------------------------------------------
interface serial_compare_16_if #(
    parameter int WIDTH = 16
);
    logic             iStart;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic             oBusy;
    logic             oDone;
    logic [2:0]       oData;

    modport master (
        output iStart, iData_a, iData_b,
        input  oBusy, oDone, oData
    );

    modport slave (
        input  iStart, iData_a, iData_b,
        output oBusy, oDone, oData
    );
endinterface

// File: rtl/serial_compare_16_nibble_cmp.sv
// ---------------------------------------------------------------------------
// nibble_cmp
// Purely combinational cascade stage: compares one 4-bit pair and updates
// the running {gt, lt, eq} flags.
//   nibA, nibB - nibble pair under comparison
//   flagsIn    - flags accumulated so far
//   flagsOut   - updated flags: an unequal pair overrides with its own
//                gt/lt verdict, an equal pair passes flagsIn through
// ---------------------------------------------------------------------------
import serial_cmp_pkg::*;

module nibble_cmp (
    input  logic [3:0] nibA,
    input  logic [3:0] nibB,
    input  logic [2:0] flagsIn,
    output logic [2:0] flagsOut
);
    always_comb begin
        flagsOut = flagsIn;
        if (nibA > nibB) begin
            flagsOut         = 3'b000;
            flagsOut[GT_BIT] = 1'b1;
        end else if (nibA < nibB) begin
            flagsOut         = 3'b000;
            flagsOut[LT_BIT] = 1'b1;
        end
    end
endmodule

// File: rtl/serial_compare_16.sv
// ---------------------------------------------------------------------------
// serial_compare_16
// Magnitude comparator that walks the operands one nibble per clock.
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset (wins over a start request)
//   bus  - serial_compare_16_if.slave: iStart / iData_a / iData_b in,
//          oBusy / oDone / oData out
// A start in IDLE or DONE captures both operands and enters RUN. Each RUN
// cycle feeds one nibble pair through nibble_cmp; the finishing cycle
// moves to DONE, which loads oData and pulses oDone. oData then holds
// until the next completion.
//
// Build option SERIAL_COMPARE_EARLY_EXIT_EN:
//   undefined - nibbles LSB first, always NIB RUN cycles
//   defined   - nibbles MSB first, the first unequal pair ends the compare
// ---------------------------------------------------------------------------
import serial_cmp_pkg::*;

module serial_compare_16 #(
    parameter  int WIDTH = 16,          // multiple of 4, at least 8
    localparam int NIB   = WIDTH / 4    // derived, never overridden
) (
    input  logic               clk,
    input  logic               rst,
    serial_compare_16_if.slave bus
);
    localparam int STEP_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIB - 1);

    stateT              stateReg;
    stateT              stateNext;
    logic [STEP_W-1:0]  stepReg;
    logic [WIDTH-1:0]   opAReg;
    logic [WIDTH-1:0]   opBReg;
    logic [2:0]         flagsReg;
    logic [2:0]         flagsNext;
    logic [2:0]         oDataReg;

    logic [3:0]         nibAArr [NIB];
    logic [3:0]         nibBArr [NIB];
    logic [STEP_W-1:0]  nibIdx;
    logic [3:0]         curA;
    logic [3:0]         curB;
    logic               startAccept;
    logic               lastStep;
    logic               busyComb;
    logic               doneComb;

    // Slice the captured operands into nibble arrays for the step mux.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign nibAArr[gi] = opAReg[4*gi +: 4];
            assign nibBArr[gi] = opBReg[4*gi +: 4];
        end
    endgenerate

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    // MSB first: step k looks at the k-th nibble counted from the top.
    assign nibIdx   = LAST_STEP - stepReg;
    assign curA     = nibAArr[nibIdx];
    assign curB     = nibBArr[nibIdx];
    // The first unequal pair settles the answer, so stop there.
    assign lastStep = (stepReg == LAST_STEP) || (curA != curB);
`else
    // LSB first: a later (more significant) unequal pair overrides earlier
    // verdicts, so every nibble has to be visited.
    assign nibIdx   = stepReg;
    assign curA     = nibAArr[nibIdx];
    assign curB     = nibBArr[nibIdx];
    assign lastStep = (stepReg == LAST_STEP);
`endif

    nibble_cmp u_nibble_cmp (
        .nibA     (curA),
        .nibB     (curB),
        .flagsIn  (flagsReg),
        .flagsOut (flagsNext)
    );

    assign startAccept = bus.iStart && ((stateReg == IDLE) || (stateReg == DONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (bus.iStart) stateNext = RUN;
            RUN:     if (lastStep)   stateNext = DONE;
            DONE:    stateNext = bus.iStart ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busyComb = 1'b0;
        doneComb = 1'b0;
        case (stateReg)
            RUN:     busyComb = 1'b1;
            DONE:    doneComb = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, step counter, cascade flags and result register.
    // The counter holds at LAST_STEP on the finishing cycle instead of
    // wrapping; the next accepted start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            opAReg   <= '0;
            opBReg   <= '0;
            stepReg  <= '0;
            flagsReg <= FLAGS_EQ;
            oDataReg <= 3'b000;
        end else if (startAccept) begin
            opAReg   <= bus.iData_a;
            opBReg   <= bus.iData_b;
            stepReg  <= '0;
            flagsReg <= FLAGS_EQ;
        end else if (stateReg == RUN) begin
            flagsReg <= flagsNext;
            if (lastStep) begin
                oDataReg <= flagsNext;
            end else begin
                stepReg <= stepReg + STEP_W'(1);
            end
        end
    end

    assign bus.oBusy = busyComb;
    assign bus.oDone = doneComb;
    assign bus.oData = oDataReg;

endmodule

// File: tb/tb_serial_compare_16.sv
// ---------------------------------------------------------------------------
// tb_serial_compare_16
// Self-checking bench for serial_compare_16. Expected results come from a
// plain integer compare of the operands; expected latency comes from where
// the operands first differ. Latency is counted with the first cycle after
// the accepting clock edge as cycle 1.
// ---------------------------------------------------------------------------
module tb_serial_compare_16;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_compare_16_if #(.WIDTH(WIDTH)) bus ();

    serial_compare_16 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
        for (int i = 0; i < NIB; i++) begin
            if (a[WIDTH-1-4*i -: 4] != b[WIDTH-1-4*i -: 4]) return i + 2;
        end
        return NIB + 1;
`else
        if (a == b) return NIB + 1;  // same either way; keeps both args used
        return NIB + 1;
`endif
    endfunction

    // ---------------- stimulus helper (no checking) ----------------
    // Entered and left at a falling edge. Optionally pulses iStart in RUN
    // cycles 2 and 3, and scrambles the operand inputs after the start.
    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit pulseMid, output int lat,
                           output logic [2:0] res, output bit tmo);
        bus.iStart  = 1'b1;
        bus.iData_a = a;
        bus.iData_b = b;
        @(posedge clk);
        @(negedge clk);
        bus.iStart  = 1'b0;
        bus.iData_a = WIDTH'($urandom);
        bus.iData_b = WIDTH'($urandom);
        lat = 0;
        tmo = 1'b1;
        res = 3'bxxx;
        for (int n = 0; n < 40; n++) begin
            lat++;
            if (bus.oDone === 1'b1) begin
                tmo = 1'b0;
                res = bus.oData;
                break;
            end
            bus.iStart = pulseMid && (lat == 2 || lat == 3);
            @(posedge clk);
            @(negedge clk);
            bus.iStart = 1'b0;
        end
        $display("txn a=%h b=%h result=%b latency=%0d timeout=%0d", a, b, res, lat, tmo);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst         = 1'b1;
        bus.iStart  = 1'b1;   // reset must win over start
        bus.iData_a = 16'hA5A5;
        bus.iData_b = 16'h5A5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.oBusy); end
        total++; if (bus.oDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.oDone); end
        total++; if (bus.oData !== 3'b000) begin bad++; $display("FAIL reset_data: got %b expected 000", bus.oData); end
        rst        = 1'b0;
        bus.iStart = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b expected 0", bus.oBusy); end
        $display("txn reset checked");
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [3] = '{16'h1234, 16'h8000, 16'h0001};
        logic [WIDTH-1:0] tb [3] = '{16'h1234, 16'h7FFF, 16'h0002};
        int lat;
        logic [2:0] res;
        bit tmo;
        for (int i = 0; i < 3; i++) begin
            run_txn(ta[i], tb[i], 1'b0, lat, res, tmo);
            total++; if (tmo) begin bad++; $display("FAIL directed%0d_timeout: no oDone within 40 cycles", i); end
            total++; if (res !== ref_result(ta[i], tb[i])) begin bad++; $display("FAIL directed%0d_result: got %b expected %b", i, res, ref_result(ta[i], tb[i])); end
            total++; if (lat != ref_latency(ta[i], tb[i])) begin bad++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, ref_latency(ta[i], tb[i])); end
            @(posedge clk);
            @(negedge clk);
            total++; if (bus.oDone !== 1'b0) begin bad++; $display("FAIL directed%0d_pulse: got oDone=%b expected 0", i, bus.oDone); end
            total++; if (bus.oData !== ref_result(ta[i], tb[i])) begin bad++; $display("FAIL directed%0d_hold: got %b expected %b", i, bus.oData, ref_result(ta[i], tb[i])); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [2:0] res;
        bit tmo;
        int extra;
        run_txn(16'hFFFF, 16'h0000, 1'b1, lat, res, tmo);
        total++; if (tmo) begin bad++; $display("FAIL ignore_timeout: no oDone within 40 cycles"); end
        total++; if (res !== 3'b100) begin bad++; $display("FAIL ignore_result: got %b expected 100", res); end
        total++; if (lat != ref_latency(16'hFFFF, 16'h0000)) begin bad++; $display("FAIL ignore_latency: got %0d expected %0d", lat, ref_latency(16'hFFFF, 16'h0000)); end
        extra = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.oDone === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL ignore_single_done: got %0d extra pulses expected 0", extra); end
        total++; if (bus.oData !== 3'b100) begin bad++; $display("FAIL ignore_hold: got %b expected 100", bus.oData); end
    endtask

    task automatic test_back_to_back();
        bit seen1 = 1'b0;
        bit seen2 = 1'b0;
        logic [2:0] res1 = 3'bxxx;
        logic [2:0] res2 = 3'bxxx;
        int gap = 0;
        bus.iStart  = 1'b1;
        bus.iData_a = 16'hFFFF;
        bus.iData_b = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        bus.iData_a = 16'h0000;   // next operands, iStart stays high
        bus.iData_b = 16'hFFFF;
        for (int n = 0; n < 40; n++) begin
            if (bus.oDone === 1'b1) begin seen1 = 1'b1; res1 = bus.oData; break; end
            @(posedge clk);
            @(negedge clk);
        end
        if (seen1) begin
            for (int n = 0; n < 40; n++) begin
                @(posedge clk);
                @(negedge clk);
                gap++;
                if (gap == 1) begin
                    total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL b2b_restart: got busy=%b expected 1", bus.oBusy); end
                end
                if (bus.oDone === 1'b1) begin seen2 = 1'b1; res2 = bus.oData; break; end
            end
        end
        bus.iStart = 1'b0;
        $display("txn b2b first=%b second=%b gap=%0d", res1, res2, gap);
        total++; if (!seen1) begin bad++; $display("FAIL b2b_first_timeout: no first oDone"); end
        total++; if (!seen2) begin bad++; $display("FAIL b2b_second_timeout: no second oDone"); end
        total++; if (res1 !== 3'b100) begin bad++; $display("FAIL b2b_first_result: got %b expected 100", res1); end
        total++; if (res2 !== 3'b010) begin bad++; $display("FAIL b2b_second_result: got %b expected 010", res2); end
        total++; if (gap != ref_latency(16'h0000, 16'hFFFF)) begin bad++; $display("FAIL b2b_gap: got %0d expected %0d", gap, ref_latency(16'h0000, 16'hFFFF)); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int lat;
        logic [2:0] res;
        bit tmo;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        // Operands differ only in the lowest nibble so the compare is still
        // running in cycle 3 in either build.
        bus.iStart  = 1'b1;
        bus.iData_a = 16'h1235;
        bus.iData_b = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL abort_running: got busy=%b expected 1", bus.oBusy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", bus.oBusy); end
        total++; if (bus.oData !== 3'b000) begin bad++; $display("FAIL abort_data: got %b expected 000", bus.oData); end
        for (int n = 0; n < 8; n++) begin
            if (bus.oDone === 1'b1) dones++;
            @(posedge clk);
            @(negedge clk);
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        run_txn(a, b, 1'b0, lat, res, tmo);
        total++; if (tmo) begin bad++; $display("FAIL abort_fresh_timeout: no oDone within 40 cycles"); end
        total++; if (res !== ref_result(a, b)) begin bad++; $display("FAIL abort_fresh_result: got %b expected %b", res, ref_result(a, b)); end
        total++; if (lat != ref_latency(a, b)) begin bad++; $display("FAIL abort_fresh_latency: got %0d expected %0d", lat, ref_latency(a, b)); end
    endtask

    task automatic test_random();
        int lat;
        logic [2:0] res;
        bit tmo;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int k;
        for (int i = 0; i < 24; i++) begin
            a = WIDTH'($urandom);
            case (i % 4)
                0: b = WIDTH'($urandom);
                1: b = a;
                default: begin
                    // same operand except one random nibble
                    k = int'($urandom_range(NIB - 1, 0));
                    b = a;
                    b[4*k +: 4] = 4'($urandom);
                end
            endcase
            if (i == 5)  begin a = '0; b = '0; end
            if (i == 9)  begin a = '1; b = '1; end
            run_txn(a, b, 1'b0, lat, res, tmo);
            total++; if (tmo) begin bad++; $display("FAIL rand%0d_timeout: no oDone within 40 cycles", i); end
            total++; if (res !== ref_result(a, b)) begin bad++; $display("FAIL rand%0d_result: got %b expected %b", i, res, ref_result(a, b)); end
            total++; if (lat != ref_latency(a, b)) begin bad++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, ref_latency(a, b)); end
        end
        bus.iStart = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.iStart  = 1'b0;
        bus.iData_a = '0;
        bus.iData_b = '0;
        rst         = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
